// File: rtl/up_dacbuf_wavegen_if.sv
// ---------------------------------------------------------------------------
// up_dacbuf_wavegen_if
//  Up write bus between the waveform loader (master) and the DAC buffer
//  register/sample-RAM block (slave).
//  Signals:
//   up_wreq   master->slave  write request, held until up_wack is seen
//   up_waddr  master->slave  write address (ADDRESS_WIDTH+1 bits)
//   up_wdata  master->slave  write data (32 bits)
//   up_wack   slave->master  write acknowledge
// ---------------------------------------------------------------------------
interface up_dacbuf_wavegen_if #(
    parameter int ADDRESS_WIDTH = 12
);
    logic                     up_wreq;
    logic [ADDRESS_WIDTH:0]   up_waddr;
    logic [31:0]              up_wdata;
    logic                     up_wack;

    modport master (
        output up_wreq,
        output up_waddr,
        output up_wdata,
        input  up_wack
    );

    modport slave (
        input  up_wreq,
        input  up_waddr,
        input  up_wdata,
        output up_wack
    );
endinterface

// File: rtl/up_dacbuf_wavegen.sv
// ---------------------------------------------------------------------------
// up_dacbuf_wavegen
//  On start_i, generates one period of a DC / square / sawtooth / triangle
//  waveform and writes it into the DAC buffer over the up write bus:
//  stop playback (addr 0 <= 0), fill samples (BUF_BASE+i), write last index
//  (addr 1), re-arm playback (addr 0 <= 1 or 2).
//  Ports:
//   up_clk, up_rst     clock, asynchronous active-high reset
//   start_i, abort_i   start a load (cfg_* latched) / cancel the load
//   cfg_wave/last/lo/hi/step/async   waveform configuration
//   busy_o, done_o, err_o            status (err_o sticky until next start)
//   up_bus             up write bus, master side
// ---------------------------------------------------------------------------
module up_dacbuf_wavegen #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DACBUF_SIZE   = 8,
    parameter int DACDAT_WIDTH  = 14,
    parameter int WACK_TIMEOUT  = 16
) (
    input  logic                      up_clk,
    input  logic                      up_rst,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [1:0]                cfg_wave,
    input  logic [DACBUF_SIZE:0]      cfg_last,
    input  logic [DACDAT_WIDTH-1:0]   cfg_lo,
    input  logic [DACDAT_WIDTH-1:0]   cfg_hi,
    input  logic [DACDAT_WIDTH-1:0]   cfg_step,
    input  logic                      cfg_async,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    up_dacbuf_wavegen_if.master       up_bus
);
    localparam int W  = DACDAT_WIDTH;
    localparam int IW = DACBUF_SIZE + 1;
    localparam int TW = (WACK_TIMEOUT > 1) ? $clog2(WACK_TIMEOUT) : 1;
    localparam logic [ADDRESS_WIDTH:0] BUF_BASE = (ADDRESS_WIDTH+1)'(1) << IW;

    typedef enum logic [2:0] {
        ST_IDLE, ST_STOP, ST_FILL, ST_LOAD, ST_ARM, ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            gap_q,   gap_d;
    logic [TW-1:0]   tmo_q,   tmo_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [W-1:0]    smp_q,   smp_d;
    logic            dir_q,   dir_d;      // triangle direction, 1 = down
    logic            err_q,   err_d;
    logic [1:0]      wave_q,  wave_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [W-1:0]    lo_q,    lo_d;
    logic [W-1:0]    hi_q,    hi_d;
    logic [W-1:0]    step_q,  step_d;
    logic            async_q, async_d;

    // Next sample of the period, evaluated during the gap after a FILL write.
    logic [W:0]      sum_up, lo_plus;
    logic [IW-1:0]   idx_inc;
    logic [W-1:0]    nxt_smp;
    logic            nxt_dir;

    assign sum_up  = {1'b0, smp_q} + {1'b0, step_q};
    assign lo_plus = {1'b0, lo_q} + {1'b0, step_q};
    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        nxt_smp = smp_q;
        nxt_dir = dir_q;
        case (wave_q)
            2'd0: nxt_smp = hi_q;
            2'd1: nxt_smp = (idx_inc <= (last_q >> 1)) ? hi_q : lo_q;
            2'd2: nxt_smp = smp_q + step_q;
            default: begin
                if (!dir_q) begin
                    if (sum_up > {1'b0, hi_q}) begin
                        nxt_smp = hi_q;
                        nxt_dir = 1'b1;
                    end else begin
                        nxt_smp = sum_up[W-1:0];
                    end
                end else begin
                    if ({1'b0, smp_q} < lo_plus) begin
                        nxt_smp = lo_q;
                        nxt_dir = 1'b0;
                    end else begin
                        nxt_smp = smp_q - step_q;
                    end
                end
            end
        endcase
    end

    logic in_write;
    assign in_write = (state_q == ST_STOP) || (state_q == ST_FILL) ||
                      (state_q == ST_LOAD) || (state_q == ST_ARM);

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
            tmo_q   <= '0;
            idx_q   <= '0;
            smp_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            wave_q  <= '0;
            last_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            async_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            smp_q   <= smp_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            wave_q  <= wave_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            async_q <= async_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        idx_d   = idx_q;
        smp_d   = smp_q;
        dir_d   = dir_q;
        err_d   = err_q;
        wave_d  = wave_q;
        last_d  = last_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        async_d = async_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    wave_d  = cfg_wave;
                    last_d  = cfg_last;
                    lo_d    = cfg_lo;
                    hi_d    = cfg_hi;
                    step_d  = cfg_step;
                    async_d = cfg_async;
                    err_d   = 1'b0;
                    gap_d   = 1'b0;
                    tmo_d   = '0;
                    idx_d   = '0;
                    dir_d   = 1'b0;
                    // Sample 0: saw/triangle start at lo, DC/square at hi.
                    smp_d   = cfg_wave[1] ? cfg_lo : cfg_hi;
                    state_d = ST_STOP;
                end
            end
            ST_STOP, ST_FILL, ST_LOAD, ST_ARM: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    gap_d   = 1'b0;
                end else if (!gap_q) begin
                    if (up_bus.up_wack) begin
                        // The ARM write's gap cycle is the DONE cycle.
                        if (state_q == ST_ARM) state_d = ST_DONE;
                        else                   gap_d   = 1'b1;
                    end else if (tmo_q == TW'(WACK_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    gap_d = 1'b0;
                    tmo_d = '0;
                    case (state_q)
                        ST_STOP: state_d = ST_FILL;
                        ST_FILL: begin
                            if (idx_q == last_q) begin
                                state_d = ST_LOAD;
                            end else begin
                                idx_d = idx_inc;
                                smp_d = nxt_smp;
                                dir_d = nxt_dir;
                            end
                        end
                        default: state_d = ST_ARM;  // from LOAD
                    endcase
                end
            end
            default: state_d = ST_IDLE;             // ST_DONE
        endcase
    end

    // Output stage expects the sample bit-reversed in bits W..1.
    logic [31:0] pack_w;
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pack
            if (gi >= 1 && gi <= W) begin : g_bit
                assign pack_w[gi] = smp_q[W-gi];
            end else begin : g_zero
                assign pack_w[gi] = 1'b0;
            end
        end
    endgenerate

    logic                   wreq_w;
    logic [ADDRESS_WIDTH:0] waddr_w;
    logic [31:0]            wdata_w;

    assign wreq_w = in_write && !gap_q;

    always_comb begin
        waddr_w = '0;
        wdata_w = '0;
        if (wreq_w) begin
            case (state_q)
                ST_FILL: begin
                    waddr_w = BUF_BASE + (ADDRESS_WIDTH+1)'(idx_q);
                    wdata_w = pack_w;
                end
                ST_LOAD: begin
                    waddr_w = (ADDRESS_WIDTH+1)'(1);
                    wdata_w = 32'(last_q);
                end
                ST_ARM:  wdata_w = async_q ? 32'd2 : 32'd1;
                default: wdata_w = '0;
            endcase
        end
    end

    assign up_bus.up_wreq  = wreq_w;
    assign up_bus.up_waddr = waddr_w;
    assign up_bus.up_wdata = wdata_w;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;
endmodule
